keypad_debounce_encoder: RTL

KEYPAD_DEBOUNCE_ENCODER -- requirements
Module: keypad_debounce_encoder

---
 rtl/keypad_debounce_encoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/keypad_debounce_encoder.sv
// One-hot keypad debouncer and index encoder with strobe, hold level and enable override.
// Optional auto-repeat of the strobe while a key stays pressed: define KEYPAD_REPEAT_EN.
module keypad_debounce_encoder #(
   parameter int N_KEYS          = 10,
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 8,
   parameter int REPEAT_PERIOD   = 3
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [N_KEYS-1:0] keypad,
   input  logic              enablen,
   output logic [CODE_W-1:0] D,
   output logic              code_valid,
   output logic              key_held
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

   localparam logic [CODE_W-1:0] NO_KEY  = '1;
   localparam logic [7:0]        DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0] sync_q1, sync_q2;
   state_t            state;
   logic [7:0]        db_cnt;
   logic [CODE_W-1:0] cand;
   logic              sample_zero, sample_key;
   logic [CODE_W-1:0] sample_idx;
   logic              rep_hit;

   // A legal key has exactly one bit set; multi-key samples are rejected, not prioritised.
   always_comb begin
      sample_zero = (sync_q2 == '0);
      sample_key  = !sample_zero && ((sync_q2 & (sync_q2 - N_KEYS'(1))) == '0);
      sample_idx  = NO_KEY;
      for (int i = 0; i < N_KEYS; i++) begin
         if (sync_q2[i]) sample_idx = CODE_W'(i);
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int               REP_W     = 16;
   localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD);

   logic [REP_W-1:0] rep_cnt, rep_cnt_inc;
   logic             rep_first;

   assign rep_cnt_inc = rep_cnt + REP_W'(1);
   assign rep_hit     = !enablen && (state == PRESSED) && !sample_zero &&
                        (rep_cnt_inc == (rep_first ? REP_FIRST : REP_NEXT));

   // Counts only cycles spent in PRESSED; holds its value across RELEASE.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (enablen || state == IDLE || state == DEBOUNCE) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else if (state == PRESSED && !sample_zero) begin
         if (rep_hit) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt_inc;
         end
      end
   end
`else
   assign rep_hit = 1'b0;

   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_params_unused
   end
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q1    <= '0;
         sync_q2    <= '0;
         state      <= IDLE;
         db_cnt     <= '0;
         cand       <= NO_KEY;
         D          <= NO_KEY;
         code_valid <= 1'b0;
         key_held   <= 1'b0;
      end else begin
         // NOTE: non-blocking here so sync_q2 takes the old sync_q1, giving two real flop stages.
         sync_q1    <= keypad;
         sync_q2    <= sync_q1;
         code_valid <= 1'b0;
         if (enablen) begin
            state    <= IDLE;
            db_cnt   <= '0;
            D        <= NO_KEY;
            key_held <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (sample_key) begin
                     cand   <= sample_idx;
                     db_cnt <= '0;
                     state  <= DEBOUNCE;
                  end
               end
               DEBOUNCE: begin
                  if (sample_key && sample_idx == cand) begin
                     if (db_cnt == DB_LAST) begin
                        state      <= PRESSED;
                        D          <= cand;
                        code_valid <= 1'b1;
                        key_held   <= 1'b1;
                     end else begin
                        db_cnt <= db_cnt + 8'd1;
                     end
                  end else begin
                     state <= IDLE;
                  end
               end
               PRESSED: begin
                  if (sample_zero) begin
                     db_cnt <= '0;
                     state  <= RELEASE;
                  end else if (rep_hit && !code_valid) begin
                     code_valid <= 1'b1;
                  end
               end
               RELEASE: begin
                  if (!sample_zero) begin
                     state <= PRESSED;
                  end else if (db_cnt == DB_LAST) begin
                     state    <= IDLE;
                     D        <= NO_KEY;
                     key_held <= 1'b0;
                  end else begin
                     db_cnt <= db_cnt + 8'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
